// File: rtl/emesh_mem_responder_pkg.sv
// Shared definitions for the emesh memory responder: packet field offsets,
// datamode encoding and the byte-lane helpers used by write steering and read-back.
package emesh_mem_responder_pkg;

  localparam int unsigned F_DM   = 1;
  localparam int unsigned F_CTRL = 3;
  localparam int unsigned F_DST  = 8;
  localparam int unsigned F_DATA = 40;
  localparam int unsigned F_SRC  = 72;

  typedef enum logic [1:0] {
    DM_BYTE   = 2'd0,
    DM_HALF   = 2'd1,
    DM_WORD   = 2'd2,
    DM_DOUBLE = 2'd3
  } datamode_e;

  // Byte offset of the access inside its doubleword, with sub-size bits dropped.
  function automatic logic [2:0] lane_off(input datamode_e dm, input logic [2:0] a);
    case (dm)
      DM_BYTE: lane_off = a;
      DM_HALF: lane_off = {a[2:1], 1'b0};
      DM_WORD: lane_off = {a[2], 2'b00};
      default: lane_off = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] byte_en(input datamode_e dm, input logic [2:0] a);
    logic [7:0] m;
    case (dm)
      DM_BYTE: m = 8'h01;
      DM_HALF: m = 8'h03;
      DM_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    byte_en = m << lane_off(dm, a);
  endfunction

  // Replicating the datum across all lanes lets the byte enables pick the right one.
  function automatic logic [63:0] wr_lanes(input datamode_e dm, input logic [31:0] lo,
                                           input logic [31:0] hi);
    case (dm)
      DM_BYTE: wr_lanes = {8{lo[7:0]}};
      DM_HALF: wr_lanes = {4{lo[15:0]}};
      DM_WORD: wr_lanes = {2{lo}};
      default: wr_lanes = {hi, lo};
    endcase
  endfunction

endpackage

// File: rtl/emesh_mem_responder_if.sv
// Emesh write/read request and read-response channels between the bridge and the responder.
interface emesh_mem_responder_if #(parameter int PW = 104);
  logic          wr_access;
  logic [PW-1:0] wr_packet;
  logic          wr_wait;
  logic          rd_access;
  logic [PW-1:0] rd_packet;
  logic          rd_wait;
  logic          rr_access;
  logic [PW-1:0] rr_packet;
  logic          rr_wait;

  modport master (
    output wr_access, wr_packet, rd_access, rd_packet, rr_wait,
    input  wr_wait, rd_wait, rr_access, rr_packet
  );

  modport slave (
    input  wr_access, wr_packet, rd_access, rd_packet, rr_wait,
    output wr_wait, rd_wait, rr_access, rr_packet
  );
endinterface

// File: rtl/emesh_rr_fifo.sv
// Read-response FIFO: DEPTH-entry store behind a registered output stage.
// An empty FIFO forwards a push straight into the output register.
module emesh_rr_fifo #(
  parameter int W     = 104,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_wait,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     store [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             load_s, from_store_s, bypass_s, to_store_s;

  assign load_s       = ~out_valid_q | ~pop_wait;
  assign from_store_s = load_s & (cnt_q != {CNT_W{1'b0}});
  assign bypass_s     = load_s & (cnt_q == {CNT_W{1'b0}}) & push;
  assign to_store_s   = push & ~bypass_s;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (from_store_s) begin
      out_valid_d = 1'b1;
      out_data_d  = store[rd_ptr_q];
    end else if (bypass_s) begin
      out_valid_d = 1'b1;
      out_data_d  = push_data;
    end else if (load_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    rd_ptr_d = from_store_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = to_store_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({to_store_s, from_store_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (to_store_s) begin
      store[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: rtl/emesh_mem_responder.sv
// Emesh memory target: byte-enabled 64-bit RAM, one-stage read pipeline, credit-limited
// read-response FIFO. Reads see writes accepted in the same cycle.
module emesh_mem_responder
  import emesh_mem_responder_pkg::*;
#(
  parameter int PW       = 104,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MW       = 10,
  parameter int RR_DEPTH = 4
) (
  input logic                  axi_aclk,
  input logic                  axi_aresetn,
  emesh_mem_responder_if.slave bus
);
  localparam int CW = $clog2(RR_DEPTH + 1);

  logic [63:0]   mem [2**MW];
  logic          wr_wait_q, wr_wait_d, rd_wait_q, rd_wait_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          rd_vld_q, rd_vld_d;
  logic [MW-1:0] rd_idx_q, rd_idx_d;
  logic [2:0]    rd_off_q, rd_off_d;
  datamode_e     rd_dm_q, rd_dm_d;
  logic [4:0]    rd_ctrl_q, rd_ctrl_d;
  logic [AW-1:0] rd_src_q, rd_src_d;

  logic          wr_acc_s, rd_acc_s, pop_s, unused_s;
  datamode_e     wr_dm_s, rq_dm_s;
  logic [MW-1:0] wr_idx_s;
  logic [7:0]    wr_be_s;
  logic [63:0]   wr_data_s, rd_word_s, lane_s;
  logic [31:0]   rsp_lo_s, rsp_hi_s;
  logic [PW-1:0] resp_pkt_s;

  assign wr_acc_s  = bus.wr_access & ~wr_wait_q;
  assign rd_acc_s  = bus.rd_access & ~rd_wait_q;
  assign pop_s     = bus.rr_access & ~bus.rr_wait;
  assign wr_dm_s   = datamode_e'(bus.wr_packet[F_DM +: 2]);
  assign rq_dm_s   = datamode_e'(bus.rd_packet[F_DM +: 2]);
  assign wr_idx_s  = bus.wr_packet[F_DST + 3 +: MW];
  assign wr_be_s   = byte_en(wr_dm_s, bus.wr_packet[F_DST +: 3]);
  assign wr_data_s = wr_lanes(wr_dm_s, bus.wr_packet[F_DATA +: DW], bus.wr_packet[F_SRC +: AW]);
  assign unused_s  = ^{bus.wr_packet[0], bus.wr_packet[F_CTRL +: 5],
                       bus.wr_packet[F_DST + MW + 3 +: AW - MW - 3],
                       bus.rd_packet[0], bus.rd_packet[F_DATA +: DW],
                       bus.rd_packet[F_DST + MW + 3 +: AW - MW - 3]};

  // RAM write port; contents survive reset.
  always_ff @(posedge axi_aclk) begin
    if (wr_acc_s) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be_s[b]) begin
          mem[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Capture the accepted read; the RAM is sampled one edge later so same-cycle writes land first.
  always_comb begin
    rd_vld_d = rd_acc_s;
    if (rd_acc_s) begin
      rd_idx_d  = bus.rd_packet[F_DST + 3 +: MW];
      rd_off_d  = lane_off(rq_dm_s, bus.rd_packet[F_DST +: 3]);
      rd_dm_d   = rq_dm_s;
      rd_ctrl_d = bus.rd_packet[F_CTRL +: 5];
      rd_src_d  = bus.rd_packet[F_SRC +: AW];
    end else begin
      rd_idx_d  = rd_idx_q;
      rd_off_d  = rd_off_q;
      rd_dm_d   = rd_dm_q;
      rd_ctrl_d = rd_ctrl_q;
      rd_src_d  = rd_src_q;
    end
  end

  assign rd_word_s = mem[rd_idx_q];
  assign lane_s    = rd_word_s >> {rd_off_q, 3'b000};

  always_comb begin
    rsp_hi_s = 32'h0000_0000;
    case (rd_dm_q)
      DM_BYTE: rsp_lo_s = {24'h00_0000, lane_s[7:0]};
      DM_HALF: rsp_lo_s = {16'h0000, lane_s[15:0]};
      DM_WORD: rsp_lo_s = lane_s[31:0];
      default: begin
        rsp_lo_s = lane_s[31:0];
        rsp_hi_s = lane_s[63:32];
      end
    endcase
    resp_pkt_s = {rsp_hi_s, rsp_lo_s, rd_src_q, rd_ctrl_q, rd_dm_q, 1'b1};
  end

  always_comb begin
    case ({rd_acc_s, pop_s})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    rd_wait_d = (credits_d == {CW{1'b0}});
    wr_wait_d = 1'b0;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_wait_q <= 1'b1;
      rd_wait_q <= 1'b1;
      credits_q <= CW'(RR_DEPTH);
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= {MW{1'b0}};
      rd_off_q  <= 3'b000;
      rd_dm_q   <= DM_BYTE;
      rd_ctrl_q <= 5'd0;
      rd_src_q  <= {AW{1'b0}};
    end else begin
      wr_wait_q <= wr_wait_d;
      rd_wait_q <= rd_wait_d;
      credits_q <= credits_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      rd_off_q  <= rd_off_d;
      rd_dm_q   <= rd_dm_d;
      rd_ctrl_q <= rd_ctrl_d;
      rd_src_q  <= rd_src_d;
    end
  end

  assign bus.wr_wait = wr_wait_q;
  assign bus.rd_wait = rd_wait_q;

  emesh_rr_fifo #(.W(PW), .DEPTH(RR_DEPTH)) u_rr_fifo (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .push      (rd_vld_q),
    .push_data (resp_pkt_s),
    .pop_wait  (bus.rr_wait),
    .out_valid (bus.rr_access),
    .out_data  (bus.rr_packet)
  );
endmodule
